req_pending_ctrl: RTL and testbench

Upstream request-capture stage for the 8-to-3 priority encoder. Synchronises eight asynchronous request lines, detects rising edges, and holds them in a sticky pending register that drives the encoder's `number` input. Takes the encoder's `code` back, offers it to a consumer over a valid/ready handshake, and clears the serviced bit on acceptance. Bit 7 has highest priority, matching the encoder.

---
 rtl/req_pkg.sv | 8 +
 rtl/sync_rise.sv | 24 ++
 rtl/req_pending_ctrl.sv | 77 +++++++
 tb/tb_req_pending_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/req_pkg.sv
// Shared sizes and service-FSM state type for the request-capture stage.
package req_pkg;
  localparam int N_REQ  = 8;
  localparam int CODE_W = 3;
  localparam logic [7:0] DROP_MAX = 8'hFF;

  typedef enum logic {IDLE, OFFER} svc_state_t;
endpackage

// File: rtl/sync_rise.sv
// One request line: SYNC_STAGES-deep synchroniser plus a history flop for rising-edge detect.
module sync_rise #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~hist_q;
endmodule

// File: rtl/req_pending_ctrl.sv
// Sticky pending register for eight async requests, offering the encoder's code
// to a consumer over valid/ready and clearing the serviced bit on acceptance.
//   state | meaning
//   IDLE  | no offer; latch code when anything is pending
//   OFFER | svc_code held stable until svc_ready
module req_pending_ctrl
  import req_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_REQ-1:0]  req_in,
  output logic [N_REQ-1:0]  number,
  input  logic [CODE_W-1:0] code,
  output logic              svc_valid,
  output logic [CODE_W-1:0] svc_code,
  input  logic              svc_ready,
  output logic [7:0]        drop_cnt
);
  svc_state_t       state;
  logic [N_REQ-1:0] rise_vec;
  logic [N_REQ-1:0] clr_vec;
  logic             accept;
  logic             drop_hit;

  for (genvar i = 0; i < N_REQ; i++) begin : g_sync
    sync_rise #(.SYNC_STAGES(SYNC_STAGES)) u_sync_rise (
      .clk  (clk),
      .rst_n(rst_n),
      .d    (req_in[i]),
      .rise (rise_vec[i])
    );
  end

  assign accept = (state == OFFER) && svc_ready;

  always_comb begin
    clr_vec = '0;
    if (accept) clr_vec[svc_code] = 1'b1;
  end

  // A rise on a bit being cleared this cycle is a fresh event, not a drop.
  assign drop_hit = |(rise_vec & number & ~clr_vec);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      number   <= '0;
      drop_cnt <= '0;
    end else begin
      number <= (number & ~clr_vec) | rise_vec;
      if (drop_hit && (drop_cnt != DROP_MAX)) drop_cnt <= drop_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      svc_code <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (number != '0) begin
            svc_code <= code;
            state    <= OFFER;
          end
        end
        OFFER: begin
          if (svc_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign svc_valid = (state == OFFER);
endmodule

// File: tb/tb_req_pending_ctrl.sv
// Directed and randomized checks of req_pending_ctrl against a behavioural model.
module tb_req_pending_ctrl;
  localparam int S = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req_in = '0;
  logic [7:0] number;
  logic [2:0] code;
  logic       svc_valid;
  logic [2:0] svc_code;
  logic       svc_ready = 1'b0;
  logic [7:0] drop_cnt;

  int total = 0;
  int bad = 0;

  // model state
  logic [7:0] smp[$];
  logic [7:0] m_num;
  logic       m_valid;
  int         m_code;
  int         m_drop;

  always #5 clk = ~clk;

  req_pending_ctrl #(.SYNC_STAGES(S)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_in   (req_in),
    .number   (number),
    .code     (code),
    .svc_valid(svc_valid),
    .svc_code (svc_code),
    .svc_ready(svc_ready),
    .drop_cnt (drop_cnt)
  );

  // external priority encoder feeding the DUT
  always_comb begin
    code = 3'd0;
    for (int i = 0; i < 8; i++) if (number[i]) code = i[2:0];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int highest(input logic [7:0] v);
    int idx = -1;
    for (int i = 7; i >= 0; i--) if (v[i] && idx < 0) idx = i;
    return idx;
  endfunction

  task automatic model_clear();
    smp.delete();
    for (int i = 0; i < S + 2; i++) smp.push_back(8'h00);
    m_num = '0; m_valid = 1'b0; m_code = 0; m_drop = 0;
  endtask

  task automatic model_step();
    logic [7:0] rise, clr, nxt;
    smp.push_front(req_in);
    void'(smp.pop_back());
    rise = smp[S] & ~smp[S+1];
    clr  = (m_valid && svc_ready) ? (8'h01 << m_code) : 8'h00;
    if (((rise & m_num & ~clr) != 0) && m_drop < 255) m_drop++;
    nxt = (m_num & ~clr) | rise;
    if (!m_valid && m_num != 0) begin
      m_code  = highest(m_num);
      m_valid = 1'b1;
    end else if (m_valid && svc_ready) begin
      m_valid = 1'b0;
    end
    m_num = nxt;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step(); else model_clear();
    @(negedge clk);
    chk("number", number, m_num);
    chk("svc_valid", svc_valid, m_valid);
    chk("svc_code", svc_code, m_code);
    chk("drop_cnt", drop_cnt, m_drop);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    model_clear();
    #1;
    chk("rst_number", number, 0);
    chk("rst_valid", svc_valid, 0);
    chk("rst_code", svc_code, 0);
    chk("rst_drop", drop_cnt, 0);
    tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_valid(input int budget);
    for (int i = 0; i < budget && !svc_valid; i++) tick();
    if (!svc_valid) chk("wait_valid_timeout", 0, 1);
  endtask

  initial begin
    logic [2:0] seq[$];
    model_clear();
    @(negedge clk);
    apply_reset();

    // single request
    svc_ready = 1'b1;
    req_in = 8'h10;
    tick(); tick(); tick();
    chk("single_number", number, 8'h10);
    req_in = 8'h00;
    tick();
    chk("single_valid", svc_valid, 1);
    chk("single_code", svc_code, 4);
    tick();
    chk("single_cleared", number, 0);
    tick(); tick();

    // priority ordering
    req_in = 8'h85;
    for (int i = 0; i < 40 && seq.size() < 3; i++) begin
      if (svc_valid && svc_ready) seq.push_back(svc_code);
      tick();
    end
    chk("prio_count", seq.size(), 3);
    if (seq.size() == 3) begin
      chk("prio_first", seq[0], 7);
      chk("prio_second", seq[1], 2);
      chk("prio_third", seq[2], 0);
    end
    req_in = 8'h00;
    for (int i = 0; i < 5; i++) tick();

    // stall and stability
    svc_ready = 1'b0;
    req_in = 8'h02;
    wait_valid(10);
    chk("stall_code", svc_code, 1);
    req_in = 8'h42;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("stall_hold", svc_code, 1);
    end
    svc_ready = 1'b1;
    tick();
    wait_valid(10);
    chk("stall_next", svc_code, 6);
    tick();
    req_in = 8'h00;
    for (int i = 0; i < 4; i++) tick();

    // set/clear collision on bit 3
    apply_reset();
    svc_ready = 1'b0;
    req_in = 8'h08;
    wait_valid(10);
    chk("coll_code", svc_code, 3);
    req_in = 8'h00;
    tick(); tick(); tick();
    req_in = 8'h08;
    tick(); tick();
    svc_ready = 1'b1;
    tick();
    chk("coll_kept", number[3], 1);
    chk("coll_drop", drop_cnt, 0);
    chk("coll_idle", svc_valid, 0);
    tick();
    chk("coll_reoffer_valid", svc_valid, 1);
    chk("coll_reoffer_code", svc_code, 3);
    tick();
    chk("coll_done", number, 0);

    // drop saturation
    apply_reset();
    svc_ready = 1'b0;
    req_in = 8'h01;
    wait_valid(10);
    for (int i = 0; i < 300; i++) begin
      req_in = 8'h00; tick();
      req_in = 8'h01; tick();
    end
    tick(); tick();
    chk("drop_sat", drop_cnt, 255);
    for (int i = 0; i < 10; i++) tick();
    chk("drop_hold", drop_cnt, 255);

    // reset mid-offer with request held through release
    chk("mid_valid_before", svc_valid, 1);
    #2;
    apply_reset();
    wait_valid(10);
    chk("mid_reoffer_code", svc_code, 0);
    svc_ready = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("mid_single_offer", svc_valid, 0);
    end

    // randomized
    req_in = 8'h00;
    for (int i = 0; i < 2000; i++) begin
      if (i % 2 == 0 && $urandom_range(0, 3) == 0) req_in = req_in ^ 8'($urandom);
      svc_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 299) == 0) apply_reset();
      else tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
